// File: rtl/stream_rx_pkg.sv
// Shared definitions for the AXI4-Stream receive front end:
// controller state encoding and the destination channel indices.
package stream_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rx_state_e;

  localparam int FEATURE_CH   = 0;
  localparam int WEIGHT_CH    = 1;
  localparam int BIAS_CH      = 2;
  localparam int LEAKYRELU_CH = 3;

endpackage

// File: rtl/stream_rx_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on dout while
// empty is low. full/empty are registered so they can gate the stream
// handshake without a combinational path from the pop side.
module stream_rx_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Occupancy after this cycle's push/pop; a simultaneous pair cancels out.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (AW+1)'(1);
      2'b01:   count_next = count - (AW+1)'(1);
      default: count_next = count;
    endcase
  end

  // Storage array; contents are don't-care while empty so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/stream_rx_demux.sv
// AXI4-Stream receive front end: accepts one transfer per command, buffers
// beats in a show-ahead FIFO, steers them to the commanded channel, checks
// the beat count and pulses write_finish once the buffer has drained.
module stream_rx_demux
  import stream_rx_pkg::*;
#(
  parameter  int DATA_W     = 64,
  parameter  int NUM_CH     = 4,
  localparam int CH_W       = $clog2(NUM_CH),
  parameter  int FIFO_DEPTH = 16,
  parameter  int LEN_W      = 16
) (
  input  logic                sclk,
  input  logic                s_rst_n,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  input  logic                cmd_start,
  input  logic [CH_W-1:0]     cmd_ch,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                busy,
  output logic                write_finish,
  output logic                len_err,
  output logic [DATA_W-1:0]   rx_data,
  output logic [DATA_W/8-1:0] rx_keep,
  output logic [NUM_CH-1:0]   rx_vld,
  input  logic                rx_rdy
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int FW     = DATA_W + KEEP_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  rx_state_e         state;
  rx_state_e         state_next;
  logic [CH_W-1:0]   ch_q;
  logic              ch_ok;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  beat_cnt;
  logic [LEN_W-1:0]  cnt_inc;
  logic              cmd_take;
  logic              cmd_ch_ok;
  logic              accept;
  logic              hit_len;
  logic              short_last;
  logic              pop;
  logic              drain_done;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [FW-1:0]     fifo_dout;

  assign cmd_take      = (state == IDLE) & cmd_start;
  assign cmd_ch_ok     = int'(cmd_ch) < NUM_CH;
  assign s_axis_tready = (state == RECV) & ~fifo_full;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign cnt_inc       = (&beat_cnt) ? beat_cnt : beat_cnt + LEN_W'(1);
  assign hit_len       = (len_q != '0) && (cnt_inc == len_q);
  assign short_last    = (len_q != '0) && s_axis_tlast && (cnt_inc < len_q);
  assign pop           = ~fifo_empty & rx_rdy;
  assign drain_done    = fifo_empty | (pop & (fifo_count == CNT_W'(1)));

  assign busy         = (state != IDLE);
  assign write_finish = (state == DONE);
  assign rx_vld       = (ch_ok & ~fifo_empty) ? (NUM_CH'(1) << ch_q) : '0;
  assign rx_data      = fifo_empty ? '0 : fifo_dout[FW-1:KEEP_W];
  assign rx_keep      = fifo_empty ? '0 : fifo_dout[KEEP_W-1:0];

  stream_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sclk),
    .rst_n (s_rst_n),
    .push  (accept),
    .din   ({s_axis_tdata, s_axis_tkeep}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Controller next state; DRAIN leaves in the cycle the last beat is popped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_start) state_next = RECV;
      RECV:    if (accept && (s_axis_tlast || hit_len)) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Command latch, saturating beat counter and sticky length error flag.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      ch_q     <= '0;
      ch_ok    <= 1'b0;
      len_q    <= '0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else if (cmd_take) begin
      ch_q     <= cmd_ch;
      ch_ok    <= cmd_ch_ok;
      len_q    <= cmd_len;
      beat_cnt <= '0;
      len_err  <= ~cmd_ch_ok;
    end else if (accept) begin
      beat_cnt <= cnt_inc;
      if (short_last || (hit_len && !s_axis_tlast)) len_err <= 1'b1;
    end
  end

endmodule
